// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: two-flop synchroniser that brings the asynchronous serial line into the clk domain.
// Latency: q follows d by 2 clocks.
// Backpressure: none; free-running.
// Ports: clk/rst_n (async active-low, flops reset to line idle level), d (async line), q (synchronised line).
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to the idle level so that releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= UART_IDLE_LEVEL;
            q    <= UART_IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 serial receiver with mid-bit sampling, framing-error and overrun flags.
// Latency: rx_valid rises 3 + HALF + 9*CLKS_PER_BIT clocks after rx is first driven low.
// Backpressure: one-byte holding register; a byte finishing while it is full and not accepted is dropped and overrun pulses.
// Ports: clk, rst_n (async active-low), rx (async line, idle high),
//        rx_data/rx_valid/rx_ready (byte output handshake), busy (FSM not idle),
//        frame_err (1-clk pulse, stop bit low), overrun (1-clk pulse, byte dropped).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    rx_state_t                 state_d;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_d;
    logic [3:0]                bit_idx;
    logic [3:0]                bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      shift_en;
    logic                      deliver;
    logic                      stop_bad;
    logic                      accept;
    logic                      load;
    logic                      drop;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame timing uses only the bit-period counter. The clock on which IDLE
    // sees the line low counts as 0, so START enters with cnt=1 and samples
    // the start bit at cnt==HALF. From then on the counter is cleared at each
    // sample and the next sample falls exactly CLKS_PER_BIT clocks later
    // (cnt==CLKS_PER_BIT-1), keeping every sample at mid-bit.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        bit_idx_d = bit_idx;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        // Line already back high at mid-start: treat as a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_en  = 1'b1;
                    bit_idx_d = bit_idx + 4'd1;
                    if (bit_idx == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        // Rest of the stop bit is high, so IDLE can catch the next start edge.
                        state_d = IDLE;
                        deliver = 1'b1;
                    end else begin
                        state_d  = WAIT_IDLE;
                        stop_bad = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Park here through a break so it yields a single frame_err.
                cnt_d = '0;
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
        end
    end

    // A completed byte may load when the holder is empty or is being drained
    // in the same clock; otherwise the holder keeps the older byte.
    assign accept = rx_valid && rx_ready;
    assign load   = deliver && (!rx_valid || rx_ready);
    assign drop   = deliver && rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // LSB arrives first: shift right with the new bit entering at the MSB.
            if (shift_en) begin
                shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            end
            if (load) begin
                rx_data <= shreg;
            end
            if (load) begin
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            frame_err <= stop_bad;
            overrun   <= drop;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       rx4;
    logic [7:0] rx_data4;
    logic       rx_valid4;
    logic       rx_ready4;
    logic       busy4;
    logic       frame_err4;
    logic       overrun4;

    logic       rx2;
    logic [7:0] rx_data2;
    logic       rx_valid2;
    logic       rx_ready2;
    logic       busy2;
    logic       frame_err2;
    logic       overrun2;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx4),
        .rx_data   (rx_data4),
        .rx_valid  (rx_valid4),
        .rx_ready  (rx_ready4),
        .busy      (busy4),
        .frame_err (frame_err4),
        .overrun   (overrun4)
    );

    uart_rx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx2),
        .rx_data   (rx_data2),
        .rx_valid  (rx_valid2),
        .rx_ready  (rx_ready2),
        .busy      (busy2),
        .frame_err (frame_err2),
        .overrun   (overrun2)
    );

    int total = 0;
    int bad   = 0;

    // Event tallies, sampled on the falling edge while inputs and outputs are stable.
    int         fe4 = 0, ov4 = 0, n4 = 0;
    int         fe2 = 0, ov2 = 0, n2 = 0;
    logic [7:0] got4 [0:31];
    logic [7:0] got2 [0:31];

    always @(negedge clk) begin
        if (frame_err4) fe4++;
        if (overrun4)   ov4++;
        if (rx_valid4 && rx_ready4) begin
            got4[n4[4:0]] = rx_data4;
            n4++;
        end
        if (frame_err2) fe2++;
        if (overrun2)   ov2++;
        if (rx_valid2 && rx_ready2) begin
            got2[n2[4:0]] = rx_data2;
            n2++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 2) rx2 = v;
        else          rx4 = v;
    endtask

    // Drives one 10-bit frame: start 0, data LSB first, then the given stop level.
    task automatic send(input int sel, input logic [7:0] b, input logic stop_bit);
        int         cpb;
        logic [9:0] fr;
        cpb = (sel == 2) ? 2 : 4;
        fr  = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            set_line(sel, fr[k]);
            tick(cpb);
        end
    endtask

    int fb, ob, nb, bc;

    initial begin
        rst_n     = 1'b0;
        rx4       = 1'b1;
        rx2       = 1'b1;
        rx_ready4 = 1'b0;
        rx_ready2 = 1'b0;
        tick(3);

        // Reset state
        chk("rst_data4",  32'(rx_data4),   32'h00);
        chk("rst_valid4", 32'(rx_valid4),  32'd0);
        chk("rst_busy4",  32'(busy4),      32'd0);
        chk("rst_fe4",    32'(frame_err4), 32'd0);
        chk("rst_ov4",    32'(overrun4),   32'd0);
        chk("rst_valid2", 32'(rx_valid2),  32'd0);
        chk("rst_busy2",  32'(busy2),      32'd0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_busy4", 32'(busy4), 32'd0);

        // T1: 0xA5, ready high; valid is a single clock, 41 clocks after rx first low
        rx_ready4 = 1'b1;
        fb = fe4; ob = ov4; nb = n4;
        send(4, 8'hA5, 1'b1);
        chk("t1_valid_early", 32'(rx_valid4), 32'd0);
        tick(1);
        chk("t1_valid", 32'(rx_valid4), 32'd1);
        chk("t1_data",  32'(rx_data4),  32'hA5);
        tick(1);
        chk("t1_valid_drop", 32'(rx_valid4), 32'd0);
        chk("t1_count", 32'(n4 - nb), 32'd1);
        chk("t1_byte",  32'(got4[nb[4:0]]), 32'hA5);
        chk("t1_flags", 32'((fe4 - fb) + (ov4 - ob)), 32'd0);
        tick(4);

        // T2: 0x3C then 0xC3 back to back with ready low -> overrun on the second
        rx_ready4 = 1'b0;
        fb = fe4; ob = ov4; nb = n4;
        send(4, 8'h3C, 1'b1);
        send(4, 8'hC3, 1'b1);
        chk("t2_ov_early", 32'(ov4 - ob), 32'd0);
        tick(1);
        chk("t2_ov_pulse", 32'(overrun4),  32'd1);
        chk("t2_hold",     32'(rx_data4),  32'h3C);
        chk("t2_valid",    32'(rx_valid4), 32'd1);
        tick(1);
        chk("t2_ov_end",   32'(overrun4),  32'd0);
        chk("t2_ov_count", 32'(ov4 - ob),  32'd1);
        chk("t2_fe_count", 32'(fe4 - fb),  32'd0);
        rx_ready4 = 1'b1;
        tick(1);
        chk("t2_drained",  32'(rx_valid4), 32'd0);
        chk("t2_count",    32'(n4 - nb),   32'd1);
        chk("t2_byte",     32'(got4[nb[4:0]]), 32'h3C);
        tick(4);

        // T3: stop bit low plus a long break -> one frame_err, busy until line high
        fb = fe4; ob = ov4; nb = n4;
        send(4, 8'h00, 1'b0);
        chk("t3_fe_early", 32'(frame_err4), 32'd0);
        tick(1);
        chk("t3_fe_pulse", 32'(frame_err4), 32'd1);
        tick(1);
        chk("t3_fe_end",   32'(frame_err4), 32'd0);
        tick(38);
        rx4 = 1'b1;
        tick(2);
        chk("t3_busy_wait", 32'(busy4), 32'd1);
        tick(1);
        chk("t3_busy_fall", 32'(busy4), 32'd0);
        chk("t3_fe_count",  32'(fe4 - fb), 32'd1);
        chk("t3_no_byte",   32'(n4 - nb),  32'd0);
        chk("t3_no_ov",     32'(ov4 - ob), 32'd0);
        tick(4);

        // T4: one-clock low glitch; START holds HALF clocks after the detect clock
        // (HALF+1 counting the detect clock itself)
        fb = fe4; ob = ov4; nb = n4; bc = 0;
        rx4 = 1'b0;
        tick(1);
        rx4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (busy4) bc++;
        end
        chk("t4_busy_len", 32'((bc >= 2) && (bc <= 3)), 32'd1);
        chk("t4_idle",     32'(busy4), 32'd0);
        chk("t4_quiet",    32'((fe4 - fb) + (ov4 - ob) + (n4 - nb)), 32'd0);

        // T5: reset during DATA, then a clean 0x5A
        fb = fe4; ob = ov4; nb = n4;
        rx4 = 1'b0;
        tick(4);
        rx4 = 1'b1;
        tick(8);
        chk("t5_in_frame", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        tick(2);
        chk("t5_rst_data", 32'(rx_data4), 32'h00);
        chk("t5_rst_busy", 32'(busy4),    32'd0);
        rst_n = 1'b1;
        tick(30);
        chk("t5_post_busy",  32'(busy4),     32'd0);
        chk("t5_post_valid", 32'(rx_valid4), 32'd0);
        send(4, 8'h5A, 1'b1);
        tick(1);
        chk("t5_valid", 32'(rx_valid4), 32'd1);
        chk("t5_data",  32'(rx_data4),  32'h5A);
        tick(1);
        chk("t5_count", 32'(n4 - nb), 32'd1);
        chk("t5_flags", 32'((fe4 - fb) + (ov4 - ob)), 32'd0);
        tick(4);

        // T6: CLKS_PER_BIT=2, 0xFF then 0x01, ready pulsed on the second load clock
        ob = ov2; nb = n2;
        send(2, 8'hFF, 1'b1);
        send(2, 8'h01, 1'b1);
        chk("t6_first_valid", 32'(rx_valid2), 32'd1);
        chk("t6_first_data",  32'(rx_data2),  32'hFF);
        tick(1);
        chk("t6_pre_load", 32'(rx_data2), 32'hFF);
        rx_ready2 = 1'b1;
        tick(1);
        rx_ready2 = 1'b0;
        chk("t6_hand_valid", 32'(rx_valid2), 32'd1);
        chk("t6_hand_data",  32'(rx_data2),  32'h01);
        chk("t6_hand_ov",    32'(overrun2),  32'd0);
        tick(3);
        chk("t6_hold_valid", 32'(rx_valid2), 32'd1);
        rx_ready2 = 1'b1;
        tick(1);
        rx_ready2 = 1'b0;
        chk("t6_drained", 32'(rx_valid2), 32'd0);
        chk("t6_count",   32'(n2 - nb),   32'd2);
        chk("t6_byte0",   32'(got2[nb[4:0]]), 32'hFF);
        nb = nb + 1;
        chk("t6_byte1",   32'(got2[nb[4:0]]), 32'h01);
        chk("t6_no_ov",   32'(ov2 - ob),  32'd0);
        chk("t6_no_fe",   32'(fe2),       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
